regfile_dump_reader: RTL and testbench

Debug read-out engine for the 8-bit CPU register file. On a `start` pulse it walks the register file's second read port through R0..R(NUM_REGS-1), captures each byte, and streams a framed dump over a valid/ready byte interface. It is the consumer of the register file's combinational read port. It sits beside the core and feeds the debug/UART path.

---
 rtl/regfile_dump_reader_if.sv | 13 +
 rtl/regfile_dump_reader.sv | 159 +++++++++++++++
 tb/tb_regfile_dump_reader.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_dump_reader_if.sv
// Byte stream (valid/ready) carrying the framed register dump.
// The master drives valid/data/last and the slave returns ready.
interface regfile_dump_reader_if #(
  parameter int DATA_W = 8
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (output out_valid, output out_data, output out_last, input out_ready);
  modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/regfile_dump_reader.sv
// Walks the register file's second read port and streams a framed dump: header, R0..R(NUM_REGS-1).
// Define REGFILE_DUMP_CHECKSUM_EN to append a modulo-2^DATA_W sum byte after the register bytes.
module regfile_dump_reader #(
  parameter int                NUM_REGS = 4,
  parameter int                ADDR_W   = 3,
  parameter int                DATA_W   = 8,
  parameter logic [DATA_W-1:0] HDR_BYTE = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic [DATA_W-1:0]     rd_data,
  regfile_dump_reader_if.master out_if,
  output logic                  busy,
  output logic                  done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_READ,
    S_SEND
`ifdef REGFILE_DUMP_CHECKSUM_EN
    , S_CSUM
`endif
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_last_q, out_last_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                xfer;
`ifdef REGFILE_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0]   sum_q, sum_d;
`endif

  assign xfer = out_valid_q && out_if.out_ready;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
    sum_d       = sum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_HDR;
          out_data_d  = HDR_BYTE;
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
          idx_d       = '0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
          sum_d       = '0;
`endif
        end
      end
      S_HDR: begin
        if (xfer) begin
          state_d     = S_READ;
          out_valid_d = 1'b0;
        end
      end
      S_READ: begin
        // rd_data already reflects any same-cycle write forwarded by the register file
        out_data_d  = rd_data;
        out_valid_d = 1'b1;
`ifdef REGFILE_DUMP_CHECKSUM_EN
        out_last_d  = 1'b0;
        sum_d       = sum_q + rd_data;
`else
        out_last_d  = (idx_q == LAST_IDX);
`endif
        state_d     = S_SEND;
      end
      S_SEND: begin
        if (xfer) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (idx_q == LAST_IDX) begin
`ifdef REGFILE_DUMP_CHECKSUM_EN
            state_d     = S_CSUM;
            out_data_d  = sum_q;
            out_valid_d = 1'b1;
            out_last_d  = 1'b1;
`else
            state_d     = S_IDLE;
            done_d      = 1'b1;
`endif
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = S_READ;
          end
        end
      end
`ifdef REGFILE_DUMP_CHECKSUM_EN
      S_CSUM: begin
        if (xfer) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = S_IDLE;
          done_d      = 1'b1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
    // Outputs are registered, so derive them from the upcoming state
    busy_d    = (state_d != S_IDLE);
    rd_addr_d = (state_d == S_READ) ? idx_d : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      rd_addr_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rd_addr_q   <= rd_addr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef REGFILE_DUMP_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  assign rd_addr          = rd_addr_q;
  assign out_if.out_valid = out_valid_q;
  assign out_if.out_data  = out_data_q;
  assign out_if.out_last  = out_last_q;
  assign busy             = busy_q;
  assign done             = done_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader: expected frames queued at start, checked by a monitor.
// Honours REGFILE_DUMP_CHECKSUM_EN the same way as the design.
module tb_regfile_dump_reader;
  localparam int N = 4;
`ifdef REGFILE_DUMP_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif
  localparam int DONE_C = CSUM ? 11 : 10;

  logic       clk = 1'b0;
  logic       rst, start, busy, done;
  logic [2:0] rd_addr;
  logic [7:0] rd_data;
  logic       ready_drv = 1'b0;
  int         rmode = 0;

  always #5 clk = ~clk;

  regfile_dump_reader_if #(.DATA_W(8)) bus ();
  assign bus.out_ready = ready_drv;

  regfile_dump_reader #(.NUM_REGS(N), .ADDR_W(3), .DATA_W(8), .HDR_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .start(start), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_if(bus), .busy(busy), .done(done)
  );

  // Register file stand-in with write-to-read forwarding
  logic [7:0] rf [8];
  logic       we;
  logic [2:0] wa;
  logic [7:0] wd;
  always @(posedge clk) if (we) rf[wa] <= wd;
  assign rd_data = (we && wa == rd_addr) ? wd : rf[rd_addr];

  always @(posedge clk) begin
    #1;
    case (rmode)
      0: ready_drv = 1'b1;
      1: ready_drv = ~ready_drv;
      2: ready_drv = 1'($urandom_range(0, 1));
      default: ready_drv = 1'b0;
    endcase
  end

  typedef struct { logic [7:0] data; logic last; } exp_t;
  exp_t exp_q[$];
  int   checks = 0, errors = 0;
  int   exp_dones = 0, dones_seen = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  // Expected frame from the bench's register file; ovr_idx models a write landing during the dump
  task automatic push_frame(input int ovr_idx, input logic [7:0] ovr_val);
    exp_t e;
    logic [7:0] s = 8'h00;
    logic [7:0] v;
    e.data = 8'hA5; e.last = 1'b0; exp_q.push_back(e);
    for (int i = 0; i < N; i++) begin
      v = (i == ovr_idx) ? ovr_val : rf[i];
      s = s + v;
      e.data = v; e.last = (i == N - 1) && !CSUM; exp_q.push_back(e);
    end
    if (CSUM) begin
      e.data = s; e.last = 1'b1; exp_q.push_back(e);
    end
    exp_dones++;
  endtask

  // Monitor: pops on every accepted byte, checks held bytes stay stable
  exp_t       mon_e;
  logic       hold_pending = 1'b0;
  logic [7:0] hold_data;
  logic       hold_last;
  always @(negedge clk) begin
    if (rst) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        check("hold_valid", 32'(bus.out_valid), 32'd1);
        check("hold_data", 32'(bus.out_data), 32'(hold_data));
        check("hold_last", 32'(bus.out_last), 32'(hold_last));
      end
      if (bus.out_valid && bus.out_ready) begin
        $display("xfer data=%02h last=%0b t=%0t", bus.out_data, bus.out_last, $time);
        if (exp_q.size() == 0) begin
          check("unexpected_byte", 32'(bus.out_data), 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          check("byte_data", 32'(bus.out_data), 32'(mon_e.data));
          check("byte_last", 32'(bus.out_last), 32'(mon_e.last));
        end
        hold_pending = 1'b0;
      end else if (bus.out_valid) begin
        hold_pending = 1'b1;
        hold_data    = bus.out_data;
        hold_last    = bus.out_last;
      end else begin
        hold_pending = 1'b0;
      end
      if (done) begin
        dones_seen++;
        check("done_with_valid", 32'(bus.out_valid), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [7:0] v);
    we = 1'b1; wa = a; wd = v;
    tick();
    we = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit restart);
    int n = 0;
    do begin
      @(negedge clk); n++;
    end while (!done && n < budget);
    check("done_timeout", 32'(done), 32'd1);
    if (restart && done) begin
      start = 1'b1;
      push_frame(-1, 8'h00);
      tick();
      start = 1'b0;
      check("restart_hdr_valid", 32'(bus.out_valid), 32'd1);
      check("restart_hdr_data", 32'(bus.out_data), 32'hA5);
    end else begin
      tick();
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    push_frame(-1, 8'h00);
    tick();
    start = 1'b0;
  endtask

  logic [7:0] init_vals [4];
  bit         exp_v, exp_l;
  logic [7:0] exp_d;
  logic [2:0] exp_a;

  initial begin
    rst = 1'b1; start = 1'b0; we = 1'b0; wa = '0; wd = '0;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_data", 32'(bus.out_data), 32'd0);
    check("rst_last", 32'(bus.out_last), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_addr", 32'(rd_addr), 32'd0);

    init_vals[0] = 8'h11; init_vals[1] = 8'h22; init_vals[2] = 8'h33; init_vals[3] = 8'h44;
    for (int i = 0; i < 8; i++) write_reg(3'(i), (i < N) ? init_vals[i] : 8'(i));

    // Directed cycle-accurate frame with ready held high (cycle 0 = start)
    rmode = 0;
    tick();
    pulse_start();
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      exp_v = ((c % 2 == 1) && c <= 9) || (CSUM && c == 10);
      exp_l = CSUM ? (c == 10) : (c == 9);
      exp_d = (c == 1) ? 8'hA5 : (c == 10) ? 8'hAA : ((c >= 3 && c <= 9) ? init_vals[(c - 3) / 2] : 8'h00);
      exp_a = (c % 2 == 0 && c >= 2 && c <= 8) ? 3'((c - 2) / 2) : 3'd0;
      check($sformatf("c%0d_valid", c), 32'(bus.out_valid), 32'(exp_v));
      if (exp_v) begin
        check($sformatf("c%0d_data", c), 32'(bus.out_data), 32'(exp_d));
        check($sformatf("c%0d_last", c), 32'(bus.out_last), 32'(exp_l));
      end
      check($sformatf("c%0d_done", c), 32'(done), 32'(c == DONE_C));
      check($sformatf("c%0d_busy", c), 32'(busy), 32'(c < DONE_C));
      check($sformatf("c%0d_addr", c), 32'(rd_addr), 32'(exp_a));
    end
    tick();

    // Ready toggling every cycle
    rmode = 1;
    pulse_start();
    wait_done(100, 1'b0);

    // Start pulses during a frame are ignored
    rmode = 0;
    tick();
    pulse_start();
    for (int c = 1; c < DONE_C; c++) begin
      start = (c == 2 || c == 5);
      @(negedge clk);
      check($sformatf("busy_c%0d", c), 32'(busy), 32'd1);
      tick();
    end
    start = 1'b0;
    @(negedge clk);
    check("ignored_start_done", 32'(done), 32'd1);
    check("ignored_start_busy", 32'(busy), 32'd0);
    repeat (4) tick();
    check("no_second_frame", 32'(bus.out_valid), 32'd0);

    // Same-cycle write to R2 during its READ cycle
    start = 1'b1;
    push_frame(2, 8'h5A);
    tick();
    start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (rd_addr == 3'd2) begin
        we = 1'b1; wa = 3'd2; wd = 8'h5A;
        tick();
        we = 1'b0;
        break;
      end
      tick();
    end
    wait_done(100, 1'b0);

    // Reset while R1 is held in SEND under backpressure
    pulse_start();
    for (int k = 0; k < 20 && rd_addr != 3'd1; k++) tick();
    rmode = 3;
    tick();
    rst = 1'b1;
    exp_q.delete();
    exp_dones--;
    tick();
    rst = 1'b0;
    check("abort_valid", 32'(bus.out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_addr", 32'(rd_addr), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_last", 32'(bus.out_last), 32'd0);
    rmode = 0;
    repeat (2) tick();
    pulse_start();
    wait_done(100, 1'b0);

    // Checksum wrap pattern, random backpressure, back-to-back restart in the done cycle
    write_reg(3'd0, 8'hFF); write_reg(3'd1, 8'hFF);
    write_reg(3'd2, 8'hFF); write_reg(3'd3, 8'h03);
    rmode = 2;
    pulse_start();
    wait_done(200, 1'b1);
    wait_done(200, 1'b0);

    // Randomised frames
    for (int f = 0; f < 15; f++) begin
      for (int i = 0; i < N; i++) write_reg(3'(i), 8'($urandom_range(0, 255)));
      rmode = (f % 3 == 0) ? 0 : 2;
      pulse_start();
      wait_done(200, 1'b0);
    end

    repeat (4) tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("done_count", 32'(dones_seen), 32'(exp_dones));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
